// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback stage, 32x32 register file with write bypass and RAW scoreboard
// Optional retire counter and last-retired PC are built only when WB_RETIRE_CNT_EN is defined.
module writeback_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int PEND_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid_in,
  input  logic [DATA_WIDTH-1:0] wb_result,
  input  logic [ADDR_WIDTH-1:0] wb_pc,
  input  logic [INST_WIDTH-1:0] wb_instruction,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  issue_valid,
  input  logic                  issue_has_rd,
  input  logic [4:0]            issue_rd,
  input  logic                  system_stall,
  output logic                  raw_hazard,
  output logic                  issue_accept,
  output logic [31:0]           retire_count,
  output logic [ADDR_WIDTH-1:0] last_retired_pc
);

  logic [4:0]            wb_rd;
  logic                  we;
  logic                  inc;
  logic [DATA_WIDTH-1:0] regs_q [32];
  logic [PEND_W-1:0]     pend_q [32];
  logic [PEND_W-1:0]     pend_d [32];
  logic [PEND_W-1:0]     eff1;
  logic [PEND_W-1:0]     eff2;
  logic                  rd_full;
  logic                  unused_inputs;

  assign wb_rd = wb_instruction[11:7];
  assign we    = wb_valid_in && (wb_rd != 5'd0);

  // Register file: entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else if (we) begin
      regs_q[wb_rd] <= wb_result;
    end
  end

  // Write-first bypass so a consumer in the retiring cycle sees the new value.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = (we && wb_rd == rs1_addr) ? wb_result : regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      rs2_data = (we && wb_rd == rs2_addr) ? wb_result : regs_q[rs2_addr];
    end
  end

  // A write retiring this cycle no longer counts as pending for readers.
  assign eff1    = pend_q[rs1_addr] - PEND_W'(we && wb_rd == rs1_addr);
  assign eff2    = pend_q[rs2_addr] - PEND_W'(we && wb_rd == rs2_addr);
  assign rd_full = (pend_q[issue_rd] == {PEND_W{1'b1}}) && !(we && wb_rd == issue_rd);

  assign raw_hazard = issue_valid &&
                      ((rs1_used && eff1 != '0) ||
                       (rs2_used && eff2 != '0) ||
                       (issue_has_rd && rd_full));

  assign issue_accept = issue_valid && !raw_hazard && !system_stall;
  assign inc          = issue_accept && issue_has_rd && (issue_rd != 5'd0);

  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < 32; r++) begin
      if ((inc && issue_rd == 5'(r)) && !(we && wb_rd == 5'(r))) begin
        pend_d[r] = pend_q[r] + PEND_W'(1);
      end else if (!(inc && issue_rd == 5'(r)) && (we && wb_rd == 5'(r)) &&
                   pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '{default: '0};
    end else begin
      pend_q <= pend_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && we && pend_q[wb_rd] == '0 && !(inc && issue_rd == wb_rd)) begin
      $error("writeback to x%0d with no pending write outstanding", wb_rd);
    end
  end
`endif

`ifdef WB_RETIRE_CNT_EN
  logic [31:0]           retire_count_q;
  logic [ADDR_WIDTH-1:0] last_pc_q;

  // Counts every retirement, including results discarded to x0.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count_q <= '0;
      last_pc_q      <= '0;
    end else if (wb_valid_in) begin
      retire_count_q <= retire_count_q + 32'd1;
      last_pc_q      <= wb_pc;
    end
  end

  assign retire_count    = retire_count_q;
  assign last_retired_pc = last_pc_q;
`else
  assign retire_count    = '0;
  assign last_retired_pc = '0;
`endif

  assign unused_inputs = ^{wb_pc, wb_instruction[INST_WIDTH-1:12], wb_instruction[6:0]};

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - scoreboard-driven bench for writeback_regfile
module tb_writeback_regfile;

`ifdef WB_RETIRE_CNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid_in;
  logic [31:0] wb_result;
  logic [31:0] wb_pc;
  logic [31:0] wb_instruction;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_used, rs2_used;
  logic [31:0] rs1_data, rs2_data;
  logic        issue_valid, issue_has_rd;
  logic [4:0]  issue_rd;
  logic        system_stall;
  logic        raw_hazard, issue_accept;
  logic [31:0] retire_count;
  logic [31:0] last_retired_pc;

  logic [31:0] exp_q[$];
  logic [31:0] e;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  writeback_regfile dut (
    .clk(clk), .reset(reset),
    .wb_valid_in(wb_valid_in), .wb_result(wb_result), .wb_pc(wb_pc),
    .wb_instruction(wb_instruction),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
    .system_stall(system_stall),
    .raw_hazard(raw_hazard), .issue_accept(issue_accept),
    .retire_count(retire_count), .last_retired_pc(last_retired_pc)
  );

  task automatic clear_inputs();
    wb_valid_in = 0; wb_result = '0; wb_pc = '0; wb_instruction = '0;
    rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
    issue_valid = 0; issue_has_rd = 0; issue_rd = 0; system_stall = 0;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
    wb_valid_in = 1; wb_result = d; wb_pc = pc;
    wb_instruction = {20'h0, rd, 7'h33};
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic has_rd);
    issue_valid = 1; issue_has_rd = has_rd; issue_rd = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rs1_addr = 5; rs2_addr = 31; rs1_used = 1; rs2_used = 1; issue_valid = 1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL reset_rs1_data: got %h expected %h", rs1_data, e); end
    e = exp_q.pop_front(); checks++;
    if (rs2_data !== e) begin errors++; $display("FAIL reset_rs2_data: got %h expected %h", rs2_data, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL reset_raw_hazard: got %b expected %h", raw_hazard, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL reset_issue_accept: got %b expected %h", issue_accept, e); end
    e = exp_q.pop_front(); checks++;
    if (retire_count !== e) begin errors++; $display("FAIL reset_retire_count: got %h expected %h", retire_count, e); end
    e = exp_q.pop_front(); checks++;
    if (last_retired_pc !== e) begin errors++; $display("FAIL reset_last_pc: got %h expected %h", last_retired_pc, e); end
    system_stall = 1;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL reset_stall_accept: got %b expected %h", issue_accept, e); end
    next_cycle();
  endtask

  task automatic test_bypass();
    set_issue(5, 1);
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL bypass_issue_accept: got %b expected %h", issue_accept, e); end
    next_cycle();
    set_wb(5, 32'hDEADBEEF, 32'h100); rs1_addr = 5;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rs1_data, e); end
    next_cycle();
    rs1_addr = 5;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(RC_EN ? 32'd1 : 32'd0);
    exp_q.push_back(RC_EN ? 32'h100 : 32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL bypass_committed: got %h expected %h", rs1_data, e); end
    e = exp_q.pop_front(); checks++;
    if (retire_count !== e) begin errors++; $display("FAIL bypass_retire_count: got %h expected %h", retire_count, e); end
    e = exp_q.pop_front(); checks++;
    if (last_retired_pc !== e) begin errors++; $display("FAIL bypass_last_pc: got %h expected %h", last_retired_pc, e); end
    next_cycle();
  endtask

  task automatic test_x0_write();
    set_wb(0, 32'h1234, 32'h104); rs1_addr = 0; rs2_addr = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL x0_bypass_rs1: got %h expected %h", rs1_data, e); end
    e = exp_q.pop_front(); checks++;
    if (rs2_data !== e) begin errors++; $display("FAIL x0_bypass_rs2: got %h expected %h", rs2_data, e); end
    next_cycle();
    rs1_addr = 0;
    exp_q.push_back(32'h0);
    exp_q.push_back(RC_EN ? 32'd2 : 32'd0);
    exp_q.push_back(RC_EN ? 32'h104 : 32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL x0_after_write: got %h expected %h", rs1_data, e); end
    e = exp_q.pop_front(); checks++;
    if (retire_count !== e) begin errors++; $display("FAIL x0_retire_count: got %h expected %h", retire_count, e); end
    e = exp_q.pop_front(); checks++;
    if (last_retired_pc !== e) begin errors++; $display("FAIL x0_last_pc: got %h expected %h", last_retired_pc, e); end
    next_cycle();
  endtask

  task automatic test_raw_hazard();
    set_issue(7, 1);
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL raw_first_accept: got %b expected %h", issue_accept, e); end
    next_cycle();
    issue_valid = 1; rs2_used = 1; rs2_addr = 7;
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL raw_hazard_set: got %b expected %h", raw_hazard, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL raw_accept_held: got %b expected %h", issue_accept, e); end
    set_wb(7, 32'hA5A50007, 32'h108);
    exp_q.push_back(32'h0); exp_q.push_back(32'hA5A50007); exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL raw_hazard_bypassed: got %b expected %h", raw_hazard, e); end
    e = exp_q.pop_front(); checks++;
    if (rs2_data !== e) begin errors++; $display("FAIL raw_rs2_bypass: got %h expected %h", rs2_data, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL raw_accept_released: got %b expected %h", issue_accept, e); end
    next_cycle();
    issue_valid = 1; rs2_used = 1; rs2_addr = 7;
    exp_q.push_back(32'h0); exp_q.push_back(32'hA5A50007);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL raw_pend_cleared: got %b expected %h", raw_hazard, e); end
    e = exp_q.pop_front(); checks++;
    if (rs2_data !== e) begin errors++; $display("FAIL raw_rs2_committed: got %h expected %h", rs2_data, e); end
    next_cycle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      set_issue(3, 1);
      exp_q.push_back(32'h1);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL sat_fill_accept_%0d: got %b expected %h", i, issue_accept, e); end
      next_cycle();
    end
    set_issue(3, 1);
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL sat_guard: got %b expected %h", raw_hazard, e); end
    set_wb(3, 32'h33, 32'h10C);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL sat_guard_with_wb: got %b expected %h", raw_hazard, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL sat_accept_with_wb: got %b expected %h", issue_accept, e); end
    next_cycle();
    set_issue(3, 1);
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL sat_pend_still_full: got %b expected %h", raw_hazard, e); end
    next_cycle();
  endtask

  task automatic test_stall();
    set_issue(9, 1);
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL stall_pre_accept: got %b expected %h", issue_accept, e); end
    next_cycle();
    system_stall = 1; set_issue(9, 1); set_wb(9, 32'h99, 32'h110); rs1_addr = 9;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h99);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL stall_accept: got %b expected %h", issue_accept, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL stall_raw_hazard: got %b expected %h", raw_hazard, e); end
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL stall_wb_bypass: got %h expected %h", rs1_data, e); end
    next_cycle();
    issue_valid = 1; rs1_used = 1; rs1_addr = 9;
    exp_q.push_back(32'h0); exp_q.push_back(32'h99);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL stall_pend_unchanged: got %b expected %h", raw_hazard, e); end
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL stall_wb_committed: got %h expected %h", rs1_data, e); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_issue(4, 1);
      exp_q.push_back(32'h1);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, issue_accept} !== e) begin errors++; $display("FAIL rmid_fill_accept_%0d: got %b expected %h", i, issue_accept, e); end
      next_cycle();
    end
    set_wb(4, 32'h55, 32'h114);
    next_cycle();
    issue_valid = 1; rs1_used = 1; rs1_addr = 4;
    exp_q.push_back(32'h1); exp_q.push_back(32'h55);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL rmid_pend2_hazard: got %b expected %h", raw_hazard, e); end
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL rmid_reg4: got %h expected %h", rs1_data, e); end
    next_cycle();
    reset = 1; set_wb(4, 32'h77, 32'h118);
    next_cycle();
    reset = 0;
    issue_valid = 1; rs1_used = 1; rs1_addr = 4; rs2_used = 1; rs2_addr = 3;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'b0, raw_hazard} !== e) begin errors++; $display("FAIL rmid_hazard_cleared: got %b expected %h", raw_hazard, e); end
    e = exp_q.pop_front(); checks++;
    if (rs1_data !== e) begin errors++; $display("FAIL rmid_reg4_cleared: got %h expected %h", rs1_data, e); end
    e = exp_q.pop_front(); checks++;
    if (retire_count !== e) begin errors++; $display("FAIL rmid_retire_count: got %h expected %h", retire_count, e); end
    e = exp_q.pop_front(); checks++;
    if (last_retired_pc !== e) begin errors++; $display("FAIL rmid_last_pc: got %h expected %h", last_retired_pc, e); end
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_bypass();
    test_x0_write();
    test_raw_hazard();
    test_saturation();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
